// File: rtl/compare_pkg.sv
// compare_pkg: result encodings and FSM state type shared by the serial comparator
package compare_pkg;
  localparam logic [2:0] Y_GT  = 3'b100;
  localparam logic [2:0] Y_EQ  = 3'b010;
  localparam logic [2:0] Y_LT  = 3'b001;
  localparam logic [2:0] Y_RST = 3'b000;
  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/compare_digit.sv
// compare_digit: combinational unsigned compare of one DIGIT-bit slice
module compare_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);
  assign gt = a > b;
  assign lt = a < b;
endmodule

// File: rtl/compare_serial.sv
// compare_serial: MSB-first digit-serial magnitude compare with early exit
module compare_serial
  import compare_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       y
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb;
  logic [KW-1:0] k;
  logic [DIGIT-1:0] da, db;
  logic gt, lt, last, fin, load;
  logic [WIDTH-1:0] sign_flip;
  assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign da = ra[(NDIG-1-int'(k))*DIGIT +: DIGIT];
  assign db = rb[(NDIG-1-int'(k))*DIGIT +: DIGIT];
  assign last = k == KW'(NDIG-1);
  assign fin = (state == SCAN) && (gt || lt || last);
  assign load = (state == IDLE) && start;
  compare_digit #(.DIGIT(DIGIT)) u_digit (
    .a (da),
    .b (db),
    .gt(gt),
    .lt(lt)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: leave IDLE on start, leave SCAN on first difference or last digit
  always_comb
    state_n = (state == IDLE) ? (start ? SCAN : IDLE) : (fin ? IDLE : SCAN);
  // busy spans exactly the SCAN cycles
  always_comb
    busy = state == SCAN;
  // operand capture (sign bits flipped so signed order becomes unsigned order) and digit index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      k  <= '0;
    end else if (load) begin
      ra <= a ^ sign_flip;
      rb <= b ^ sign_flip;
      k  <= '0;
    end else if (state == SCAN && !fin) begin
      k <= k + 1'b1;
    end
  // result registers updated only on the finishing edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done <= 1'b0;
      y    <= Y_RST;
    end else begin
      done <= fin;
      if (fin) y <= gt ? Y_GT : (lt ? Y_LT : Y_EQ);
    end
endmodule

// File: tb/tb_compare_serial.sv
// tb_compare_serial: vector table, corner sequences and randomized back-to-back compares
module tb_compare_serial;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG = WIDTH / DIGIT;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic busy, done;
  logic [2:0] y;
  int n_vec = 0;
  int n_bad = 0;

  compare_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    logic [2:0]       y;
    int               lat;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_y(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z, input logic sm);
    if (sm) return ($signed(x) > $signed(z)) ? 3'b100 : ($signed(x) < $signed(z)) ? 3'b001 : 3'b010;
    return (x > z) ? 3'b100 : (x < z) ? 3'b001 : 3'b010;
  endfunction

  function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
    int d;
    int v;
    int m;
    v = int'(x ^ z);
    m = (1 << DIGIT) - 1;
    for (d = 0; d < NDIG; d++)
      if (((v >> (WIDTH - DIGIT * (d + 1))) & m) != 0) return d + 1;
    return NDIG;
  endfunction

  // called #1 after a rising edge with the DUT idle
  task automatic run(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tsm,
                     output logic [2:0] ry, output int lat, output bit bok);
    a = ta;
    b = tb;
    signed_mode = tsm;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bok = busy;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
      if (!done && !busy) bok = 1'b0;
      if (done && busy) bok = 1'b0;
    end while (!done && lat < NDIG + 3);
    ry = y;
  endtask

  initial begin
    logic [2:0] ry;
    int lat, cnt, ndone;
    bit bok;
    logic [WIDTH-1:0] ca, cb, na, nb;
    logic csm, nsm;
    vt[0] = '{16'h1010, 16'h1100, 1'b0, 3'b001, 2};
    vt[1] = '{16'h8000, 16'h0001, 1'b0, 3'b100, 1};
    vt[2] = '{16'h8000, 16'h0001, 1'b1, 3'b001, 1};
    vt[3] = '{16'hABCD, 16'hABCD, 1'b0, 3'b010, 4};
    vt[4] = '{16'hABCE, 16'hABCD, 1'b0, 3'b100, 4};
    vt[5] = '{16'hFFFF, 16'h0000, 1'b1, 3'b001, 1};
    vt[6] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};
    vt[7] = '{16'h1234, 16'h1234, 1'b1, 3'b010, 4};

    #2 rst_n = 1'b0;
    #20;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_y", int'(y), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      run(vt[i].a, vt[i].b, vt[i].sm, ry, lat, bok);
      chk($sformatf("vec%0d_y", i), int'(ry), int'(vt[i].y));
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy", i), int'(bok), 1);
    end

    // second start and operand change while busy are ignored
    a = 16'h1234; b = 16'h1235; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; a = 16'h0000;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; lat = 2; ry = 3'b000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (ndone == 0) lat++;
      if (done) begin ndone++; ry = y; end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_y", int'(ry), 3'b001);
    chk("ign_lat", lat, 4);

    // asynchronous reset during an equal-operand scan
    a = 16'h5A5A; b = 16'h5A5A; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_y", int'(y), 0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    run(16'h0F00, 16'h0E00, 1'b0, ry, lat, bok);
    chk("rst_after_y", int'(ry), 3'b100);
    chk("rst_after_lat", lat, 2);

    // back-to-back with start held high and random operand pairs
    ca = 16'($urandom); cb = 16'($urandom); csm = 1'($urandom);
    a = ca; b = cb; signed_mode = csm; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 1000; i++) begin
      #1;
      chk("b2b_busy_rise", int'(busy), 1);
      nsm = 1'($urandom);
      na = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? (na ^ 16'(1 << $urandom_range(0, 15))) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) nb = na;
      a = na; b = nb; signed_mode = nsm;
      cnt = 0;
      do begin
        @(posedge clk);
        #1 cnt++;
      end while (!done && cnt < NDIG + 3);
      chk("b2b_y", int'(y), int'(ref_y(ca, cb, csm)));
      chk("b2b_lat", cnt, ref_lat(ca, cb));
      ca = na; cb = nb; csm = nsm;
      @(posedge clk);
    end
    #1 start = 1'b0;
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
